regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised next-generation register file: DATA_W-bit entries, 2**ADDR_W deep, two combinational read ports, one synchronous write port.
- Adds a synchronous reset, optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard.
- The scoreboard lets the datapath controller reserve a destination register and stall readers until the result is written back.
- Sits between the decode/control FSM and the ALU/writeback path, replacing the fixed 16x16 register file.

Parameters:
- DATA_W, 16, width of each register in bits.
- ADDR_W, 4, register address width; depth N = 2**ADDR_W.
- ZERO_REG, 0. When 1, register 0 always reads 0, ignores writes and can never be reserved.
- BYPASS, 1. When 1, a same-cycle write to a register being read is forwarded to the read port.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- a_reg  in  ADDR_W  read port A address
- b_reg  in  ADDR_W  read port B address
- a_out  out  DATA_W  read port A data (combinational)
- b_out  out  DATA_W  read port B data (combinational)
- a_busy  out  1  register a_reg is reserved (combinational)
- b_busy  out  1  register b_reg is reserved (combinational)
- wr_en  in  1  write enable
- wr_reg  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve request for rsv_reg
- rsv_reg  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation accepted this cycle (combinational)
- busy_count  out  ADDR_W+1  number of currently reserved registers

Behaviour:
Reset:
- Synchronous: on a clk edge with reset=1, all registers go to 0, all busy bits to 0, and busy_count to 0.
- Reset overrides any write or reservation in the same cycle.
- A reset asserted mid-reservation drops every pending reservation with no writeback.

Reads:
- Zero latency. a_out = reg[a_reg] and b_out = reg[b_reg].
- With BYPASS=1, if wr_en && wr_reg == a_reg, then a_out = wr_data; same for port B.
- With ZERO_REG=1, address 0 reads 0 regardless of BYPASS.
- a_busy/b_busy are the current stored busy bits. They are not bypassed by a same-cycle write; the bit clears on the next edge.

Writes:
- On a clk edge with wr_en=1, reg[wr_reg] <= wr_data and busy[wr_reg] <= 0.
- A write to a non-busy register is legal and does not affect busy_count.
- With ZERO_REG=1, writes to register 0 are discarded.

Reservation:
- rsv_ok = rsv_en && !(ZERO_REG && rsv_reg == 0) && (!busy[rsv_reg] || (wr_en && wr_reg == rsv_reg)).
- On an edge with rsv_ok=1, busy[rsv_reg] <= 1.
- A rejected request (rsv_ok=0) changes nothing; the requester must hold and retry.
- Same-cycle write and reserve to the same register: the data is written, busy ends at 1 (the new producer wins), and busy_count is unchanged if the register was already busy.

busy_count:
- Registered, equal to the population count of the busy bits after each edge.
- Per edge: +1 if a reservation sets a previously clear bit; -1 if a write clears a previously set bit (and that register was not re-reserved the same cycle); net 0 if both events occur on different registers.
- Never exceeds N (N-1 with ZERO_REG=1) and never underflows.

Test Plan:
- Reset: write 0x1234 to r5, pulse reset → a_reg=5 gives a_out=0x0000; all busy=0; busy_count=0.
- Write/read with BYPASS=1: wr_en=1, wr_reg=3, wr_data=0xBEEF, a_reg=3 in the same cycle → a_out=0xBEEF before the edge. With BYPASS=0 → a_out shows the old value, 0xBEEF after the edge.
- Reservation:
  - Reserve r7 → rsv_ok=1, next cycle a_busy=1 (a_reg=7), busy_count=1.
  - Second reserve of r7 → rsv_ok=0, count stays 1.
  - Write r7=0x0042 → busy clears, count=0, a_out=0x0042.
- Simultaneous write and reserve on r2 while busy: rsv_ok=1, r2=wr_data, busy stays 1, count unchanged. The same pattern on different registers (write r4 busy, reserve r9) → count unchanged, r4 clear, r9 busy.
- ZERO_REG=1: write 0xFFFF to r0 → a_out=0; reserve r0 → rsv_ok=0; busy_count=0.
- Fill and reset: reserve all 16 registers over 16 cycles → busy_count=16. Assert reset with a simultaneous write → count=0, all busy clear, the written register reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, one write port,
// optional hardwired-zero r0, optional write-to-read bypass and a busy scoreboard.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [ADDR_W-1:0] b_reg,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              a_busy,
  output logic              b_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              rsv_ok,
  output logic [ADDR_W:0]   busy_count
);

  localparam int            N       = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  logic [DATA_W-1:0] r_mem [N];
  logic [N-1:0]      r_busy;
  logic [ADDR_W:0]   r_busy_count;

  logic w_wr_act;
  logic w_rsv_ok;
  logic w_cnt_inc;
  logic w_cnt_dec;

  assign w_wr_act = wr_en && !(ZERO_REG != 0 && wr_reg == '0);
  assign w_rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_reg == '0) &&
                    (!r_busy[rsv_reg] || (wr_en && wr_reg == rsv_reg));

  // A same-cycle re-reservation keeps the bit set, so it must not count as a release.
  assign w_cnt_inc = w_rsv_ok && !r_busy[rsv_reg];
  assign w_cnt_dec = w_wr_act && r_busy[wr_reg] && !(w_rsv_ok && rsv_reg == wr_reg);

  // NOTE: every default is assigned before the conditional overrides, so no latch is inferred.
  always_comb begin
    a_out = r_mem[a_reg];
    b_out = r_mem[b_reg];
    if (BYPASS != 0 && wr_en && wr_reg == a_reg) a_out = wr_data;
    if (BYPASS != 0 && wr_en && wr_reg == b_reg) b_out = wr_data;
    if (ZERO_REG != 0 && a_reg == '0) a_out = '0;
    if (ZERO_REG != 0 && b_reg == '0) b_out = '0;
  end

  // NOTE: every entry is cleared on reset, so the array maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (w_wr_act) begin
        r_mem[wr_reg]  <= wr_data;
        r_busy[wr_reg] <= 1'b0;
      end
      // NOTE: this later non-blocking assignment wins, so a new producer overrides a same-cycle writeback.
      if (w_rsv_ok) r_busy[rsv_reg] <= 1'b1;
      case ({w_cnt_inc, w_cnt_dec})
        2'b10:   r_busy_count <= r_busy_count + CNT_ONE;
        2'b01:   r_busy_count <= r_busy_count - CNT_ONE;
        default: r_busy_count <= r_busy_count;
      endcase
    end
  end

  assign a_busy     = r_busy[a_reg];
  assign b_busy     = r_busy[b_reg];
  assign rsv_ok     = w_rsv_ok;
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two register-file configurations share one stimulus stream and are
// compared against an array-based reference model through an expectation queue.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  a_reg = '0, b_reg = '0, wr_reg = '0, rsv_reg = '0;
  logic        wr_en = 1'b0, rsv_en = 1'b0;
  logic [15:0] wr_data = '0;

  logic [15:0] a_out0, b_out0, a_out1, b_out1;
  logic        a_busy0, b_busy0, a_busy1, b_busy1, rsv_ok0, rsv_ok1;
  logic [4:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Configuration 0: plain file with bypass. Configuration 1: zero register, no bypass.
  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
    .clk(clk), .reset(reset), .a_reg(a_reg), .b_reg(b_reg), .a_out(a_out0), .b_out(b_out0),
    .a_busy(a_busy0), .b_busy(b_busy0), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .rsv_ok(rsv_ok0), .busy_count(cnt0));

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
    .clk(clk), .reset(reset), .a_reg(a_reg), .b_reg(b_reg), .a_out(a_out1), .b_out(b_out1),
    .a_busy(a_busy1), .b_busy(b_busy1), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg), .rsv_ok(rsv_ok1), .busy_count(cnt1));

  typedef struct {
    int          dut;
    logic [15:0] a_out, b_out;
    logic        a_busy, b_busy, rsv_ok;
    logic [4:0]  cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain arrays, count derived by summing busy flags.
  bit          cfg_zero [2] = '{0, 1};
  bit          cfg_byp  [2] = '{1, 0};
  logic [15:0] m_mem  [2][16];
  bit          m_busy [2][16];
  bit          m_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input int d, input logic [3:0] addr);
    if (cfg_zero[d] && addr == 0) return 16'h0;
    if (cfg_byp[d] && wr_en && wr_reg == addr) return wr_data;
    return m_mem[d][addr];
  endfunction

  function automatic bit m_rsv_ok(input int d);
    if (!rsv_en) return 0;
    if (cfg_zero[d] && rsv_reg == 0) return 0;
    return !m_busy[d][rsv_reg] || (wr_en && wr_reg == rsv_reg);
  endfunction

  function automatic int m_count(input int d);
    int s = 0;
    for (int i = 0; i < 16; i++) s += int'(m_busy[d][i]);
    return s;
  endfunction

  // One clock cycle: drive at the falling edge, queue expectations, advance the model at the rising edge.
  task automatic cycle(input logic rst, input logic [3:0] ar, input logic [3:0] br,
                       input logic we, input logic [3:0] wreg, input logic [15:0] wdat,
                       input logic re, input logic [3:0] rreg);
    bit ok [2];
    exp_t e;
    @(negedge clk);
    reset = rst; a_reg = ar; b_reg = br;
    wr_en = we; wr_reg = wreg; wr_data = wdat;
    rsv_en = re; rsv_reg = rreg;
    for (int d = 0; d < 2; d++) begin
      ok[d] = m_rsv_ok(d);
      if (m_valid) begin
        e.dut    = d;
        e.a_out  = m_read(d, ar);
        e.b_out  = m_read(d, br);
        e.a_busy = m_busy[d][ar];
        e.b_busy = m_busy[d][br];
        e.rsv_ok = ok[d];
        e.cnt    = 5'(m_count(d));
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          m_mem[d][i]  = 16'h0;
          m_busy[d][i] = 0;
        end
      end else begin
        if (we && !(cfg_zero[d] && wreg == 0)) begin
          m_mem[d][wreg]  = wdat;
          m_busy[d][wreg] = 0;
        end
        if (ok[d]) m_busy[d][rreg] = 1;
      end
    end
    if (rst) m_valid = 1;
  endtask

  task automatic idle(input logic [3:0] ar, input logic [3:0] br);
    cycle(1'b0, ar, br, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
  endtask

  // Monitor: outputs are combinational, so they are valid a little after every drive point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dut == 0) begin
          check("d0_a_out", 32'(a_out0), 32'(e.a_out));
          check("d0_b_out", 32'(b_out0), 32'(e.b_out));
          check("d0_a_busy", 32'(a_busy0), 32'(e.a_busy));
          check("d0_b_busy", 32'(b_busy0), 32'(e.b_busy));
          check("d0_rsv_ok", 32'(rsv_ok0), 32'(e.rsv_ok));
          check("d0_busy_count", 32'(cnt0), 32'(e.cnt));
        end else begin
          check("d1_a_out", 32'(a_out1), 32'(e.a_out));
          check("d1_b_out", 32'(b_out1), 32'(e.b_out));
          check("d1_a_busy", 32'(a_busy1), 32'(e.a_busy));
          check("d1_b_busy", 32'(b_busy1), 32'(e.b_busy));
          check("d1_rsv_ok", 32'(rsv_ok1), 32'(e.rsv_ok));
          check("d1_busy_count", 32'(cnt1), 32'(e.cnt));
        end
      end
    end
  end

  initial begin
    logic [3:0] wr, rr;
    // Initial reset: outputs are undefined before it, so nothing is queued.
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);

    // Reset clears stored data.
    cycle(1'b0, 4'd5, 4'd0, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0);
    idle(4'd5, 4'd0);
    cycle(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    idle(4'd5, 4'd5);

    // Bypass versus registered read.
    cycle(1'b0, 4'd3, 4'd5, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0);
    idle(4'd3, 4'd3);

    // Reserve, rejected re-reserve, writeback release.
    cycle(1'b0, 4'd7, 4'd3, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    idle(4'd7, 4'd7);
    cycle(1'b0, 4'd7, 4'd0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    cycle(1'b0, 4'd7, 4'd0, 1'b1, 4'd7, 16'h0042, 1'b0, 4'd0);
    idle(4'd7, 4'd7);

    // Same-cycle write and reserve: same register, then different registers.
    cycle(1'b0, 4'd2, 4'd4, 1'b0, 4'd0, 16'h0, 1'b1, 4'd2);
    cycle(1'b0, 4'd2, 4'd4, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4);
    cycle(1'b0, 4'd2, 4'd4, 1'b1, 4'd2, 16'h5A5A, 1'b1, 4'd2);
    cycle(1'b0, 4'd2, 4'd9, 1'b1, 4'd4, 16'h0404, 1'b1, 4'd9);
    idle(4'd4, 4'd9);
    idle(4'd2, 4'd2);

    // Register zero: write and reserve attempts.
    cycle(1'b0, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 4'd0);
    cycle(1'b0, 4'd0, 4'd1, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0);
    idle(4'd0, 4'd0);

    // Fill every register, then reset with a simultaneous write.
    cycle(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'(i), 4'd15, 1'b0, 4'd0, 16'h0, 1'b1, 4'(i));
    #1;
    check("fill_count_plain", 32'(cnt0), 32'd16);
    check("fill_count_zero_reg", 32'(cnt1), 32'd15);
    cycle(1'b1, 4'd6, 4'd15, 1'b1, 4'd6, 16'hABCD, 1'b1, 4'd3);
    #1;
    check("reset_count_plain", 32'(cnt0), 32'd0);
    check("reset_count_zero_reg", 32'(cnt1), 32'd0);
    idle(4'd6, 4'd15);

    // Randomised traffic with deliberate address collisions.
    for (int n = 0; n < 600; n++) begin
      wr = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) == 0) ? wr : 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 79) == 0),
            ($urandom_range(0, 3) == 0) ? wr : 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? rr : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), wr, 16'($urandom),
            ($urandom_range(0, 2) != 0), rr);
    end
    idle(4'd0, 4'd1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
